// File: rtl/he_dft_pkg.sv
// Shared definitions for the 54-bit NTT datapath: widths, multiplier latency
// and the beat carried down the operand delay line.
package he_dft_pkg;

  localparam int unsigned DATA_WIDTH_54 = 54;
  localparam int unsigned MM54_LATENCY  = 16;
  localparam int unsigned TAG_WIDTH     = 12;

  typedef struct packed {
    logic                     valid;
    logic [DATA_WIDTH_54-1:0] a;
    logic [TAG_WIDTH-1:0]     tag;
    logic                     last;
  } beat_t;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth register shift line with a separate valid bit.
// Only the valid bits are reset; payload is qualified by valid downstream.
module pipe_delay #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];

  // Valid shift chain, cleared on reset so in-flight beats are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // Payload shift chain, no reset.
  always_ff @(posedge clk) begin
    dat[0] <= in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      dat[i] <= dat[i-1];
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/ntt_butterfly_54.sv
// Cooley-Tukey NTT butterfly back-end: aligns operand a with the modular
// multiplier product p and produces x = (a+p) mod q, y = (a-p) mod q.
// Optional: define BFLY_RANGE_CHECK_EN to add the sticky range_err output.
module ntt_butterfly_54 #(
  parameter int unsigned DATA_WIDTH = he_dft_pkg::DATA_WIDTH_54,
  parameter int unsigned MUL_LAT    = he_dft_pkg::MM54_LATENCY,
  parameter int unsigned TAG_WIDTH  = he_dft_pkg::TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] modulus,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] prod,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_last,
  output logic [TAG_WIDTH-1:0]  beat_cnt
`ifdef BFLY_RANGE_CHECK_EN
  ,
  output logic                  range_err
`endif
);

  import he_dft_pkg::*;

  localparam int unsigned PW = DATA_WIDTH + TAG_WIDTH + 1;

  logic          d_valid;
  logic [PW-1:0] d_data;
  beat_t         al;

  pipe_delay #(
    .WIDTH (PW),
    .DEPTH (MUL_LAT)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   ({in_a, in_tag, in_last}),
    .out_valid (d_valid),
    .out_data  (d_data)
  );

  // Aligned beat: the delayed operand that meets prod this cycle.
  always_comb begin
    al                    = '0;
    al.valid              = d_valid;
    {al.a, al.tag, al.last} = d_data;
  end

  logic [DATA_WIDTH:0]  q_ext;
  logic [DATA_WIDTH:0]  s1_sum;
  logic [DATA_WIDTH:0]  s1_diff;
  logic                 s1_valid;
  logic                 s1_last;
  logic [TAG_WIDTH-1:0] s1_tag;

  assign q_ext = {1'b0, modulus};

  // S1: unreduced sum and (a + q - p); q is added first so p == q stays non-negative.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_tag   <= '0;
      s1_sum   <= '0;
      s1_diff  <= '0;
    end else begin
      s1_valid <= al.valid;
      s1_last  <= al.valid & al.last;
      if (al.valid) begin
        s1_sum  <= {1'b0, al.a} + {1'b0, prod};
        s1_diff <= {1'b0, al.a} + q_ext - {1'b0, prod};
        s1_tag  <= al.tag;
      end
    end
  end

  logic [DATA_WIDTH:0] x_full;
  logic [DATA_WIDTH:0] y_full;

  // Single conditional subtraction brings both intermediates into [0, q).
  always_comb begin
    x_full = (s1_sum  >= q_ext) ? s1_sum  - q_ext : s1_sum;
    y_full = (s1_diff >= q_ext) ? s1_diff - q_ext : s1_diff;
  end

  // S2: output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_tag   <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= s1_valid;
      out_last  <= s1_valid & s1_last;
      if (s1_valid) begin
        out_x   <= x_full[DATA_WIDTH-1:0];
        out_y   <= y_full[DATA_WIDTH-1:0];
        out_tag <= s1_tag;
      end
    end
  end

  // Beats emitted since the last out_last; shows the pre-increment count
  // alongside each output and restarts at 0 after a last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (out_valid && out_last) begin
      beat_cnt <= '0;
    end else if (out_valid) begin
      beat_cnt <= beat_cnt + TAG_WIDTH'(1);
    end
  end

`ifdef BFLY_RANGE_CHECK_EN
  // Sticky flag for an out-of-range issued a or aligned product.
  always_ff @(posedge clk) begin
    if (rst) begin
      range_err <= 1'b0;
    end else if ((in_valid && (in_a >= modulus)) || (al.valid && (prod > modulus))) begin
      range_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ntt_butterfly_54.sv
// Directed self-checking bench for ntt_butterfly_54.
module tb_ntt_butterfly_54;

  localparam int MUL_LAT = 16;
  localparam logic [53:0] Q97  = 54'd97;
  localparam logic [53:0] QBIG = 54'h3F_FFFF_FFFF_FFDF;  // 2^54 - 33

  logic        clk = 1'b0;
  logic        rst;
  logic [53:0] modulus;
  logic        in_valid;
  logic [53:0] in_a;
  logic [11:0] in_tag;
  logic        in_last;
  logic [53:0] prod;
  logic        out_valid;
  logic [53:0] out_x;
  logic [53:0] out_y;
  logic [11:0] out_tag;
  logic        out_last;
  logic [11:0] beat_cnt;
`ifdef BFLY_RANGE_CHECK_EN
  logic        range_err;
`endif

  always #5 clk = ~clk;

  ntt_butterfly_54 dut (
    .clk       (clk),
    .rst       (rst),
    .modulus   (modulus),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_tag    (in_tag),
    .in_last   (in_last),
    .prod      (prod),
    .out_valid (out_valid),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_tag   (out_tag),
    .out_last  (out_last),
    .beat_cnt  (beat_cnt)
`ifdef BFLY_RANGE_CHECK_EN
    ,
    .range_err (range_err)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  // Directed stream schedule with hand-computed expectations.
  int          n;
  logic        sv  [16];
  logic [53:0] sa  [16];
  logic [53:0] sp  [16];
  logic [11:0] stg [16];
  logic        sl  [16];
  logic [53:0] ex  [16];
  logic [53:0] ey  [16];
  logic [11:0] ecn [16];

  task automatic add_beat(input logic v, input logic [53:0] a, input logic [53:0] p,
                          input logic [11:0] tag, input logic last,
                          input logic [53:0] x, input logic [53:0] y, input logic [11:0] cnt);
    sv[n] = v; sa[n] = a; sp[n] = p; stg[n] = tag; sl[n] = last;
    ex[n] = x; ey[n] = y; ecn[n] = cnt;
    n++;
  endtask

  task automatic do_reset(input logic [53:0] q);
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_tag = '0; in_last = 1'b0; prod = '0;
    modulus = q;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
  endtask

  task automatic run_stream(input logic check_cnt, input string name);
    int   idx;
    logic ev;
    for (int c = 0; c < n + MUL_LAT + 2; c++) begin
      if (c < n) begin
        in_valid = sv[c]; in_a = sa[c]; in_tag = stg[c]; in_last = sl[c];
      end else begin
        in_valid = 1'b0; in_a = '0; in_tag = '0; in_last = 1'b0;
      end
      if (c >= MUL_LAT && c - MUL_LAT < n) prod = sp[c-MUL_LAT];
      else                                 prod = 54'd5;
      @(posedge clk); #1;
      idx = c - (MUL_LAT + 1);
      ev  = (idx >= 0 && idx < n) ? sv[idx] : 1'b0;
      compared++;
      if (out_valid !== ev) begin
        mismatched++;
        $display("FAIL %s valid cyc=%0d got %b want %b", name, c, out_valid, ev);
      end
      if (ev) begin
        compared++;
        if (out_x !== ex[idx]) begin
          mismatched++;
          $display("FAIL %s x beat=%0d got %0d want %0d", name, idx, out_x, ex[idx]);
        end
        compared++;
        if (out_y !== ey[idx]) begin
          mismatched++;
          $display("FAIL %s y beat=%0d got %0d want %0d", name, idx, out_y, ey[idx]);
        end
        compared++;
        if (out_tag !== stg[idx]) begin
          mismatched++;
          $display("FAIL %s tag beat=%0d got %h want %h", name, idx, out_tag, stg[idx]);
        end
        compared++;
        if (out_last !== sl[idx]) begin
          mismatched++;
          $display("FAIL %s last beat=%0d got %b want %b", name, idx, out_last, sl[idx]);
        end
        if (check_cnt) begin
          compared++;
          if (beat_cnt !== ecn[idx]) begin
            mismatched++;
            $display("FAIL %s cnt beat=%0d got %0d want %0d", name, idx, beat_cnt, ecn[idx]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset(Q97);
    compared++;
    if ({out_valid, out_x, out_y, out_tag, out_last, beat_cnt} !== '0) begin
      mismatched++;
      $display("FAIL reset outputs got v=%b x=%0d y=%0d tag=%h last=%b cnt=%0d want all 0",
               out_valid, out_x, out_y, out_tag, out_last, beat_cnt);
    end
  endtask

  // 10+20 and a bubble whose prod must be ignored.
  task automatic test_basic();
    do_reset(Q97);
    add_beat(1'b1, 54'd10, 54'd20, 12'hABC, 1'b0, 54'd30, 54'd87, 12'd0);
    add_beat(1'b0, 54'd33, 54'd96, 12'h111, 1'b0, 54'd0,  54'd0,  12'd0);
    add_beat(1'b1, 54'd50, 54'd40, 12'h5A1, 1'b0, 54'd90, 54'd10, 12'd1);
    run_stream(1'b1, "basic");
  endtask

  // Reduction boundaries at q=97, including p == q.
  task automatic test_boundary();
    do_reset(Q97);
    add_beat(1'b1, 54'd96, 54'd96, 12'h021, 1'b0, 54'd95, 54'd0, 12'd0);
    add_beat(1'b1, 54'd0,  54'd97, 12'h022, 1'b0, 54'd0,  54'd0, 12'd1);
    run_stream(1'b1, "boundary");
  endtask

  // Full-width modulus 2^54-33.
  task automatic test_wide();
    do_reset(QBIG);
    add_beat(1'b1, QBIG - 54'd1, QBIG - 54'd1, 12'hF01, 1'b0, QBIG - 54'd2, 54'd0,        12'd0);
    add_beat(1'b1, 54'd0,        QBIG - 54'd1, 12'hF02, 1'b0, QBIG - 54'd1, 54'd1,        12'd1);
    add_beat(1'b1, QBIG - 54'd1, 54'd1,        12'hF03, 1'b1, 54'd0,        QBIG - 54'd2, 12'd2);
    run_stream(1'b1, "wide");
  endtask

  // 8-beat transform, then a new transform with no gap: a=i, p=2i+1.
  task automatic test_back_to_back();
    do_reset(Q97);
    for (int i = 0; i < 11; i++) begin
      add_beat(1'b1, 54'(i), 54'(2*i + 1), 12'(12'h100 + i), (i == 7),
               54'(3*i + 1), 54'(96 - i), 12'((i < 8) ? i : i - 8));
    end
    run_stream(1'b1, "b2b");
    compared++;
    if (beat_cnt !== 12'd3) begin
      mismatched++;
      $display("FAIL b2b final cnt got %0d want 3", beat_cnt);
    end
  endtask

  // Reset while beats are in flight: nothing emerges afterwards.
  task automatic test_reset_midstream();
    int bad;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 5); in_a = 54'(c + 1); in_tag = 12'(c); in_last = (c == 4);
      prod = 54'd3;
      @(posedge clk); #1;
    end
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_tag = '0; in_last = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if ({out_valid, out_x, out_y, out_tag, out_last, beat_cnt} !== '0) bad++;
    end
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("FAIL midreset nonzero-output cycles got %0d want 0", bad);
    end
  endtask

`ifdef BFLY_RANGE_CHECK_EN
  task automatic test_range_check();
    do_reset(Q97);
    compared++;
    if (range_err !== 1'b0) begin
      mismatched++;
      $display("FAIL range_init got %b want 0", range_err);
    end
    in_valid = 1'b1; in_a = 54'd97; in_tag = 12'd1; prod = 54'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = '0;
    compared++;
    if (range_err !== 1'b1) begin
      mismatched++;
      $display("FAIL range_a got %b want 1", range_err);
    end
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; in_a = 54'd1; prod = 54'd2;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    compared++;
    if (range_err !== 1'b1) begin
      mismatched++;
      $display("FAIL range_sticky got %b want 1", range_err);
    end
    do_reset(Q97);
    for (int c = 0; c < 18; c++) begin
      in_valid = (c == 0); in_a = 54'd1;
      prod = (c == MUL_LAT) ? 54'd98 : 54'd5;
      @(posedge clk); #1;
      if (c == MUL_LAT - 1) begin
        compared++;
        if (range_err !== 1'b0) begin
          mismatched++;
          $display("FAIL range_p_early got %b want 0", range_err);
        end
      end
      if (c == MUL_LAT) begin
        compared++;
        if (range_err !== 1'b1) begin
          mismatched++;
          $display("FAIL range_p got %b want 1", range_err);
        end
      end
    end
    do_reset(Q97);
    compared++;
    if (range_err !== 1'b0) begin
      mismatched++;
      $display("FAIL range_clear got %b want 0", range_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_wide();
    test_back_to_back();
    test_reset_midstream();
`ifdef BFLY_RANGE_CHECK_EN
    test_range_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
